// File: rtl/register_file_sequencer_pkg.sv
// Shared types and default sizes for the register file sequencer.
// REGISTER_FILE_SEQUENCER_VERIFY_EN adds the VERIFY state (write read-back check).
package register_file_sequencer_package;

  localparam int DEFAULT_ADDRESS_WIDTH  = 7;
  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_REGISTER_COUNT = 8;
  localparam int DEFAULT_LENGTH_WIDTH   = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE_BEAT = 3'd1,
    ST_READ_BEAT  = 3'd2,
    ST_READ_HOLD  = 3'd3,
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
    ST_DONE       = 3'd4,
    ST_VERIFY     = 3'd5
`else
    ST_DONE       = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/register_file_sequencer_address_counter.sv
// Burst address / remaining-beat counters; load on command accept, step per beat.
module register_file_sequencer_address_counter
  import register_file_sequencer_package::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int LENGTH_WIDTH  = DEFAULT_LENGTH_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     step,
  input  logic [ADDRESS_WIDTH-1:0] load_address,
  input  logic [LENGTH_WIDTH-1:0]  load_length,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     last
);

  logic [ADDRESS_WIDTH-1:0] address_d, address_q;
  logic [LENGTH_WIDTH-1:0]  remaining_d, remaining_q;

  always_comb begin
    address_d   = address_q;
    remaining_d = remaining_q;
    if (load) begin
      address_d   = load_address;
      remaining_d = load_length;
    end else if (step) begin
      address_d   = address_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address_q   <= '0;
      remaining_q <= '0;
    end else begin
      address_q   <= address_d;
      remaining_q <= remaining_d;
    end
  end

  assign address = address_q;
  assign last    = (remaining_q == '0);

endmodule

// File: rtl/register_file_sequencer.sv
// Burst initiator for the register file port: one access per beat, range-checked commands.
// Define REGISTER_FILE_SEQUENCER_VERIFY_EN to read back and compare every written beat.
module register_file_sequencer
  import register_file_sequencer_package::*;
#(
  parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REGISTER_COUNT = DEFAULT_REGISTER_COUNT,
  parameter int LENGTH_WIDTH   = DEFAULT_LENGTH_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     command_valid,
  output logic                     command_ready,
  input  logic                     command_write,
  input  logic [ADDRESS_WIDTH-1:0] command_address,
  input  logic [LENGTH_WIDTH-1:0]  command_length,
  input  logic                     write_valid,
  output logic                     write_ready,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic                     read_valid,
  input  logic                     read_ready,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     done,
  output logic                     error,
  output logic                     busy,
  output logic                     register_write,
  output logic [ADDRESS_WIDTH-1:0] register_address,
  output logic [DATA_WIDTH-1:0]    register_input_data,
  input  logic [DATA_WIDTH-1:0]    register_output_data
);

  state_t                  state_d, state_q;
  logic                    error_d, error_q;
  logic [DATA_WIDTH-1:0]   read_data_d, read_data_q;
  logic                    load, step, last;
  logic [ADDRESS_WIDTH:0]  end_address;
  logic                    out_of_range;
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
  logic [DATA_WIDTH-1:0]   write_data_d, write_data_q;
`endif

  // Extra bit so address+length cannot wrap before the compare.
  assign end_address  = {1'b0, command_address}
                      + {{(ADDRESS_WIDTH+1-LENGTH_WIDTH){1'b0}}, command_length};
  assign out_of_range = end_address > (ADDRESS_WIDTH+1)'(REGISTER_COUNT - 1);

  register_file_sequencer_address_counter #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .LENGTH_WIDTH  (LENGTH_WIDTH)
  ) u_address_counter (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (load),
    .step         (step),
    .load_address (command_address),
    .load_length  (command_length),
    .address      (register_address),
    .last         (last)
  );

  always_comb begin
    state_d      = state_q;
    error_d      = error_q;
    read_data_d  = read_data_q;
    load         = 1'b0;
    step         = 1'b0;
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
    write_data_d = write_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (command_valid) begin
          load    = 1'b1;
          error_d = out_of_range;
          if (out_of_range)       state_d = ST_DONE;
          else if (command_write) state_d = ST_WRITE_BEAT;
          else                    state_d = ST_READ_BEAT;
        end
      end
      ST_WRITE_BEAT: begin
        if (write_valid) begin
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
          write_data_d = write_data;
          state_d      = ST_VERIFY;
`else
          if (last) state_d = ST_DONE;
          else      step    = 1'b1;
`endif
        end
      end
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
      ST_VERIFY: begin
        if (register_output_data != write_data_q) error_d = 1'b1;
        if (last) state_d = ST_DONE;
        else begin
          step    = 1'b1;
          state_d = ST_WRITE_BEAT;
        end
      end
`endif
      ST_READ_BEAT: begin
        read_data_d = register_output_data;
        state_d     = ST_READ_HOLD;
      end
      ST_READ_HOLD: begin
        if (read_ready) begin
          if (last) state_d = ST_DONE;
          else begin
            step    = 1'b1;
            state_d = ST_READ_BEAT;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      error_q      <= 1'b0;
      read_data_q  <= '0;
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
      write_data_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      error_q      <= error_d;
      read_data_q  <= read_data_d;
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
      write_data_q <= write_data_d;
`endif
    end
  end

  // Decoded straight from state so reset drops register_write asynchronously.
  assign command_ready       = (state_q == ST_IDLE);
  assign write_ready         = (state_q == ST_WRITE_BEAT);
  assign register_write      = (state_q == ST_WRITE_BEAT) && write_valid;
  assign register_input_data = write_data;
  assign read_valid          = (state_q == ST_READ_HOLD);
  assign read_data           = read_data_q;
  assign done                = (state_q == ST_DONE);
  assign error               = (state_q == ST_DONE) && error_q;
  assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_register_file_sequencer.sv
// Directed bench for register_file_sequencer with a behavioural 8-entry register file.
module tb_register_file_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       command_valid = 1'b0, command_ready, command_write = 1'b0;
  logic [6:0] command_address = '0;
  logic [2:0] command_length = '0;
  logic       write_valid = 1'b0, write_ready;
  logic [7:0] write_data = '0;
  logic       read_valid, read_ready = 1'b0;
  logic [7:0] read_data;
  logic       done, error, busy, register_write;
  logic [6:0] register_address;
  logic [7:0] register_input_data, register_output_data;

  logic [7:0] regs [8];
  logic       model_init = 1'b1;
  logic       corrupt = 1'b0;
  int         tests = 0, fails = 0;

  register_file_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .command_valid(command_valid), .command_ready(command_ready),
    .command_write(command_write), .command_address(command_address),
    .command_length(command_length),
    .write_valid(write_valid), .write_ready(write_ready), .write_data(write_data),
    .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
    .done(done), .error(error), .busy(busy),
    .register_write(register_write), .register_address(register_address),
    .register_input_data(register_input_data),
    .register_output_data(register_output_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (model_init) for (int i = 0; i < 8; i++) regs[i] <= 8'(8'hA0 + i);
    else if (register_write && register_address < 7'd8)
      regs[register_address[2:0]] <= register_input_data;
  end

  assign register_output_data = (register_address < 7'd8)
    ? (regs[register_address[2:0]] ^ (corrupt ? 8'hFF : 8'h00)) : 8'h00;

  // Present a command for one edge; caller is at posedge+1 with the DUT idle.
  task automatic issue(input logic wr, input logic [6:0] a, input logic [2:0] l);
    command_valid = 1'b1; command_write = wr; command_address = a; command_length = l;
    @(posedge clock); #1;
    command_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; model_init = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %0b want 0", error); end
    tests++; if (read_valid !== 1'b0) begin fails++; $display("FAIL reset_read_valid got %0b want 0", read_valid); end
    tests++; if (register_write !== 1'b0) begin fails++; $display("FAIL reset_register_write got %0b want 0", register_write); end
    tests++; if (register_address !== 7'd0) begin fails++; $display("FAIL reset_address got %0d want 0", register_address); end
    tests++; if (read_data !== 8'h00) begin fails++; $display("FAIL reset_read_data got %h want 00", read_data); end
    tests++; if (command_ready !== 1'b1) begin fails++; $display("FAIL reset_command_ready got %0b want 1", command_ready); end
    reset_n = 1'b1; model_init = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_write_burst();
    logic [7:0] d;
    issue(1'b1, 7'd2, 3'd2);
    for (int i = 0; i < 3; i++) begin
      d = 8'(8'h11 * (i + 1));
      write_valid = 1'b1; write_data = d;
      @(negedge clock);
      tests++; if (register_write !== 1'b1) begin fails++; $display("FAIL wr_strobe beat %0d got %0b want 1", i, register_write); end
      tests++; if (register_address !== 7'(2 + i)) begin fails++; $display("FAIL wr_address beat %0d got %0d want %0d", i, register_address, 2 + i); end
      tests++; if (register_input_data !== d) begin fails++; $display("FAIL wr_data beat %0d got %h want %h", i, register_input_data, d); end
      @(posedge clock); #1;
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
      write_valid = 1'b0;
      @(negedge clock);
      tests++; if (register_write !== 1'b0 || register_address !== 7'(2 + i)) begin fails++; $display("FAIL wr_verify beat %0d got we=%0b addr=%0d want we=0 addr=%0d", i, register_write, register_address, 2 + i); end
      @(posedge clock); #1;
`endif
    end
    write_valid = 1'b0;
    @(negedge clock);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL wr_done got %0b want 1", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL wr_error got %0b want 0", error); end
    tests++; if (register_write !== 1'b0) begin fails++; $display("FAIL wr_done_strobe got %0b want 0", register_write); end
    @(posedge clock); #1;
    @(negedge clock);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL wr_done_pulse got %0b want 0", done); end
    tests++; if (regs[2] !== 8'h11 || regs[3] !== 8'h22 || regs[4] !== 8'h33) begin fails++; $display("FAIL wr_contents got %h %h %h want 11 22 33", regs[2], regs[3], regs[4]); end
    @(posedge clock); #1;
  endtask

  task automatic test_read_burst();
    logic [7:0] got [4];
    int gotc [4];
    int n = 0, dones = 0, done_c = -1;
    logic err = 1'b0;
    read_ready = 1'b1;
    issue(1'b0, 7'd2, 3'd2);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (read_valid && n < 4) begin got[n] = read_data; gotc[n] = c; n++; end
      if (done) begin done_c = c; dones++; err = error; end
      @(posedge clock); #1;
    end
    tests++; if (n !== 3) begin fails++; $display("FAIL rd_beats got %0d want 3", n); end
    tests++; if (got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin fails++; $display("FAIL rd_data got %h %h %h want 11 22 33", got[0], got[1], got[2]); end
    tests++; if (gotc[0] !== 1 || gotc[1] !== 3 || gotc[2] !== 5) begin fails++; $display("FAIL rd_timing got %0d %0d %0d want 1 3 5", gotc[0], gotc[1], gotc[2]); end
    tests++; if (done_c !== 6 || dones !== 1) begin fails++; $display("FAIL rd_done got cycle %0d count %0d want cycle 6 count 1", done_c, dones); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rd_error got %0b want 0", err); end
  endtask

  task automatic test_read_stall();
    int beats = 0, dones = 0, done_c = -1, bad = 0;
    issue(1'b0, 7'd2, 3'd2);
    for (int c = 0; c < 14; c++) begin
      read_ready = (c < 3 || c > 7);
      @(negedge clock);
      if (c >= 3 && c <= 7 && (read_valid !== 1'b1 || read_data !== 8'h22 || register_address !== 7'd3)) bad++;
      if (read_valid && read_ready) beats++;
      if (done) begin done_c = c; dones++; end
      @(posedge clock); #1;
    end
    read_ready = 1'b1;
    tests++; if (bad !== 0) begin fails++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
    tests++; if (beats !== 3) begin fails++; $display("FAIL stall_beats got %0d want 3", beats); end
    tests++; if (done_c !== 11 || dones !== 1) begin fails++; $display("FAIL stall_done got cycle %0d count %0d want cycle 11 count 1", done_c, dones); end
  endtask

  task automatic test_range_error();
    issue(1'b0, 7'd6, 3'd3);
    @(negedge clock);
    tests++; if (done !== 1'b1 || error !== 1'b1) begin fails++; $display("FAIL range_done got done=%0b err=%0b want 1 1", done, error); end
    tests++; if (command_ready !== 1'b0) begin fails++; $display("FAIL range_ready got %0b want 0", command_ready); end
    @(posedge clock); #1;
    @(negedge clock);
    tests++; if (done !== 1'b0 || command_ready !== 1'b1) begin fails++; $display("FAIL range_idle got done=%0b ready=%0b want 0 1", done, command_ready); end
    @(posedge clock); #1;
    write_valid = 1'b1; write_data = 8'hEE;
    issue(1'b1, 7'd100, 3'd0);
    @(negedge clock);
    tests++; if (done !== 1'b1 || error !== 1'b1 || register_write !== 1'b0) begin fails++; $display("FAIL range_write got done=%0b err=%0b we=%0b want 1 1 0", done, error, register_write); end
    @(posedge clock); #1;
    write_valid = 1'b0;
  endtask

  task automatic test_boundary_read();
    int n = 0, done_c = -1;
    logic [7:0] got = 8'h00;
    logic err = 1'b1;
    read_ready = 1'b1;
    issue(1'b0, 7'd7, 3'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (read_valid) begin got = read_data; n++; end
      if (done) begin done_c = c; err = error; end
      @(posedge clock); #1;
    end
    tests++; if (n !== 1 || got !== 8'hA7) begin fails++; $display("FAIL edge_read got %0d beats data %h want 1 beat a7", n, got); end
    tests++; if (done_c !== 2 || err !== 1'b0) begin fails++; $display("FAIL edge_done got cycle %0d err %0b want cycle 2 err 0", done_c, err); end
  endtask

  task automatic test_reset_mid_write();
    int dones = 0;
    issue(1'b1, 7'd0, 3'd3);
    write_valid = 1'b0;
    @(negedge clock);
    tests++; if (register_write !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wr_stall got we=%0b busy=%0b want 0 1", register_write, busy); end
    @(posedge clock); #1;
    write_valid = 1'b1; write_data = 8'h55;
    @(negedge clock);
    @(posedge clock); #1;
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
    write_valid = 1'b0;
    @(posedge clock); #1;
    write_valid = 1'b1;
`endif
    write_data = 8'h66;
    @(negedge clock);
    tests++; if (register_write !== 1'b1 || register_address !== 7'd1) begin fails++; $display("FAIL rst_pre got we=%0b addr=%0d want 1 1", register_write, register_address); end
    #1 reset_n = 1'b0;
    #1;
    tests++; if (register_write !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_async got we=%0b busy=%0b want 0 0", register_write, busy); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (done) dones++;
    end
    reset_n = 1'b1;
    write_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (done) dones++;
    end
    tests++; if (dones !== 0) begin fails++; $display("FAIL rst_no_done got %0d pulses want 0", dones); end
    tests++; if (regs[0] !== 8'h55 || regs[1] !== 8'hA1) begin fails++; $display("FAIL rst_contents got %h %h want 55 a1", regs[0], regs[1]); end
    @(posedge clock); #1;
    issue(1'b1, 7'd1, 3'd0);
    write_valid = 1'b1; write_data = 8'h77;
    @(negedge clock);
    @(posedge clock); #1;
    write_valid = 1'b0;
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
    @(posedge clock); #1;
`endif
    @(negedge clock);
    tests++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL rst_next got done=%0b err=%0b want 1 0", done, error); end
    tests++; if (regs[1] !== 8'h77) begin fails++; $display("FAIL rst_next_data got %h want 77", regs[1]); end
    @(posedge clock); #1;
  endtask

`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
  task automatic test_verify_mismatch();
    corrupt = 1'b1;
    issue(1'b1, 7'd5, 3'd1);
    write_valid = 1'b1; write_data = 8'h12;
    @(negedge clock);
    @(posedge clock); #1;
    write_valid = 1'b0;
    @(negedge clock);
    tests++; if (register_write !== 1'b0 || register_address !== 7'd5) begin fails++; $display("FAIL vfy_cycle got we=%0b addr=%0d want 0 5", register_write, register_address); end
    @(posedge clock); #1;
    corrupt = 1'b0;
    write_valid = 1'b1; write_data = 8'h34;
    @(negedge clock);
    @(posedge clock); #1;
    write_valid = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    tests++; if (done !== 1'b1 || error !== 1'b1) begin fails++; $display("FAIL vfy_error got done=%0b err=%0b want 1 1", done, error); end
    @(posedge clock); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_stall();
    test_range_error();
    test_boundary_read();
    test_reset_mid_write();
`ifdef REGISTER_FILE_SEQUENCER_VERIFY_EN
    test_verify_mismatch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
